// File: rtl/collision_pair_scheduler_if.sv
// collision_pair_scheduler_if: result handshake from the pair scheduler to
// the ball movement logic. One pair result per valid/ready transfer; index 0
// of every array belongs to the lower ball ID, index 1 to the higher one.
interface collision_pair_scheduler_if;
  logic               upd_valid;
  logic               upd_ready;
  logic        [3:0]  upd_ID     [2];
  logic signed [10:0] upd_Xspeed [2];
  logic signed [10:0] upd_Yspeed [2];

  modport master (
    output upd_valid,
    output upd_ID,
    output upd_Xspeed,
    output upd_Yspeed,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_ID,
    input  upd_Xspeed,
    input  upd_Yspeed,
    output upd_ready
  );
endinterface

// File: rtl/collision_pair_scheduler.sv
// collision_pair_scheduler: shares one combinational ball-pair speed
// calculator across every colliding pair of a frame. The collision flags are
// snapshotted at frame start, pairs are visited in lexicographic (i,j) order,
// and each result is handed to the movement logic over upd (valid/ready).
//
// Optional feature macro: SCHED_TIMEOUT_EN. When defined, a result left
// unaccepted for 256 cycles is dropped and upd_timeout pulses.
//
// state   | meaning
// IDLE    | waiting for startOfFrame
// SCAN    | testing candidate pair (i,j) against the snapshot, 1 per cycle
// DRIVE   | calc_ID/calc_collide held for CALC_WAIT cycles to settle
// CAPTURE | calculator outputs for balls i and j registered
// PRESENT | result offered on upd until accepted
module collision_pair_scheduler #(
  parameter int NUM_BALLS = 4,
  parameter int CALC_WAIT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       startOfFrame,
  input  logic [NUM_BALLS-1:0]       balls_collide,
  input  logic signed [10:0]         calc_Xspeed_in [NUM_BALLS],
  input  logic signed [10:0]         calc_Yspeed_in [NUM_BALLS],
  output logic [3:0]                 calc_ID [2],
  output logic [NUM_BALLS-1:0]       calc_collide,
  collision_pair_scheduler_if.master upd,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       frame_overrun,
  output logic [2:0]                 pair_count
`ifdef SCHED_TIMEOUT_EN
  ,
  output logic                       upd_timeout
`endif
);

  localparam int IW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DRIVE,
    CAPTURE,
    PRESENT
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [NUM_BALLS-1:0] snap_q;
  logic [IW-1:0]        i_q;
  logic [IW-1:0]        j_q;
  logic [IW-1:0]        i_nxt;
  logic [IW-1:0]        j_nxt;
  logic [3:0]           wait_q;
  logic                 pair_hit;
  logic                 last_pair;

  logic                 start_frame;
  logic                 load_wait;
  logic                 adv_ptr;
  logic                 capture;
  logic                 count_inc;
  logic                 done_set;
  logic                 pair_release;
  logic                 tmo_set;

`ifdef SCHED_TIMEOUT_EN
  logic [7:0]           tmo_cnt_q;
`endif

  assign pair_hit  = snap_q[i_q] & snap_q[j_q];
  assign last_pair = (i_q == IW'(NUM_BALLS - 2)) && (j_q == IW'(NUM_BALLS - 1));

  // Next candidate in lexicographic order: bump j, or move to row i+1.
  always_comb begin
    i_nxt = i_q;
    j_nxt = j_q + 1'b1;
    if (j_q == IW'(NUM_BALLS - 1)) begin
      i_nxt = i_q + 1'b1;
      j_nxt = i_q + IW'(2);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and one-cycle datapath strobes.
  always_comb begin
    state_d      = state_q;
    start_frame  = 1'b0;
    load_wait    = 1'b0;
    adv_ptr      = 1'b0;
    capture      = 1'b0;
    count_inc    = 1'b0;
    done_set     = 1'b0;
    pair_release = 1'b0;
    tmo_set      = 1'b0;
    case (state_q)
      IDLE: begin
        if (startOfFrame) begin
          state_d     = SCAN;
          start_frame = 1'b1;
        end
      end
      SCAN: begin
        if (pair_hit) begin
          state_d   = DRIVE;
          load_wait = 1'b1;
        end else if (last_pair) begin
          state_d  = IDLE;
          done_set = 1'b1;
        end else begin
          adv_ptr = 1'b1;
        end
      end
      DRIVE: begin
        // CALC_WAIT of 0 is outside the legal range; treat it like 1.
        if (wait_q <= 4'd1) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d = PRESENT;
        capture = 1'b1;
      end
      PRESENT: begin
        if (upd.upd_ready) begin
          count_inc    = 1'b1;
          pair_release = 1'b1;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (tmo_cnt_q == 8'd255) begin
          tmo_set      = 1'b1;
          pair_release = 1'b1;
        end
`endif
        if (pair_release) begin
          if (last_pair) begin
            state_d  = IDLE;
            done_set = 1'b1;
          end else begin
            state_d = SCAN;
            adv_ptr = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Snapshot, pair pointer, calculator drive, result registers and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q            <= '0;
      i_q               <= '0;
      j_q               <= '0;
      wait_q            <= '0;
      calc_ID[0]        <= '0;
      calc_ID[1]        <= '0;
      calc_collide      <= '0;
      upd.upd_valid     <= 1'b0;
      upd.upd_ID[0]     <= '0;
      upd.upd_ID[1]     <= '0;
      upd.upd_Xspeed[0] <= '0;
      upd.upd_Xspeed[1] <= '0;
      upd.upd_Yspeed[0] <= '0;
      upd.upd_Yspeed[1] <= '0;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
      frame_overrun     <= 1'b0;
      pair_count        <= '0;
    end else begin
      busy          <= (state_d != IDLE);
      upd.upd_valid <= (state_d == PRESENT);
      frame_done    <= done_set;
      // A frame pulse while busy is only reported; the snapshot stays.
      frame_overrun <= startOfFrame && (state_q != IDLE);

      if (start_frame) begin
        snap_q     <= balls_collide;
        i_q        <= '0;
        j_q        <= IW'(1);
        pair_count <= '0;
      end else if (adv_ptr) begin
        i_q <= i_nxt;
        j_q <= j_nxt;
      end

      if (count_inc && (pair_count != 3'd6)) begin
        pair_count <= pair_count + 3'd1;
      end

      if (load_wait) begin
        wait_q       <= 4'(CALC_WAIT);
        calc_ID[0]   <= 4'(i_q);
        calc_ID[1]   <= 4'(j_q);
        calc_collide <= (NUM_BALLS'(1) << i_q) | (NUM_BALLS'(1) << j_q);
      end else if (state_q == DRIVE) begin
        wait_q <= wait_q - 4'd1;
      end

      // Calculator inputs stay driven through CAPTURE, then return to idle.
      if (capture) begin
        upd.upd_ID[0]     <= calc_ID[0];
        upd.upd_ID[1]     <= calc_ID[1];
        upd.upd_Xspeed[0] <= calc_Xspeed_in[i_q];
        upd.upd_Xspeed[1] <= calc_Xspeed_in[j_q];
        upd.upd_Yspeed[0] <= calc_Yspeed_in[i_q];
        upd.upd_Yspeed[1] <= calc_Yspeed_in[j_q];
        calc_ID[0]        <= '0;
        calc_ID[1]        <= '0;
        calc_collide      <= '0;
      end
    end
  end

`ifdef SCHED_TIMEOUT_EN
  // Counts PRESENT cycles with upd_ready low; restarts for every new result.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q   <= '0;
      upd_timeout <= 1'b0;
    end else begin
      upd_timeout <= tmo_set;
      if (capture) begin
        tmo_cnt_q <= '0;
      end else if ((state_q == PRESENT) && !upd.upd_ready) begin
        tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_collision_pair_scheduler.sv
// tb_collision_pair_scheduler: table-driven frames, hand-written reset,
// overrun and timeout sequences, and randomized frames checked against a
// pair-list reference model. A swap-style calculator stand-in closes the loop.
module tb_collision_pair_scheduler;

  logic               clk;
  logic               reset;
  logic               startOfFrame;
  logic [3:0]         balls_collide;
  logic signed [10:0] calc_x [4];
  logic signed [10:0] calc_y [4];
  logic [3:0]         calc_ID [2];
  logic [3:0]         calc_collide;
  logic               busy;
  logic               frame_done;
  logic               frame_overrun;
  logic [2:0]         pair_count;
`ifdef SCHED_TIMEOUT_EN
  logic               upd_timeout;
`endif

  collision_pair_scheduler_if upd_if ();

  collision_pair_scheduler #(.NUM_BALLS(4), .CALC_WAIT(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (startOfFrame),
    .balls_collide  (balls_collide),
    .calc_Xspeed_in (calc_x),
    .calc_Yspeed_in (calc_y),
    .calc_ID        (calc_ID),
    .calc_collide   (calc_collide),
    .upd            (upd_if.master),
    .busy           (busy),
    .frame_done     (frame_done),
    .frame_overrun  (frame_overrun),
    .pair_count     (pair_count)
`ifdef SCHED_TIMEOUT_EN
    ,
    .upd_timeout    (upd_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Ball speeds as seen by the calculator (bx/by, written back by the
  // consumer) and as predicted by the reference model (rx/ry).
  logic signed [10:0] bx [4];
  logic signed [10:0] by [4];
  logic signed [10:0] rx [4];
  logic signed [10:0] ry [4];

  // Calculator stand-in: an elastic swap of the two selected balls' speeds.
  int ca;
  int cb;
  always_comb begin
    ca = int'(calc_ID[0]);
    cb = int'(calc_ID[1]);
    for (int k = 0; k < 4; k++) begin
      calc_x[k] = '0;
      calc_y[k] = '0;
    end
    if (ca != cb && ca < 4 && cb < 4 && calc_collide[ca] && calc_collide[cb]) begin
      calc_x[ca] = bx[cb];
      calc_x[cb] = bx[ca];
      calc_y[ca] = by[cb];
      calc_y[cb] = by[ca];
    end
  end

  typedef struct {
    int                 a;
    int                 b;
    logic signed [10:0] x0;
    logic signed [10:0] x1;
    logic signed [10:0] y0;
    logic signed [10:0] y1;
  } pair_t;

  pair_t exp_q[$];

  typedef struct {
    logic [3:0] flags;
    int         stall;
    bit         ovr;
    int         exp_done;
    int         exp_count;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: every flagged pair i<j in lexicographic order, each seeing
  // the speeds left by the pairs before it.
  task automatic model_frame(input logic [3:0] flags);
    exp_q.delete();
    for (int a = 0; a < 4; a++) begin
      for (int b = a + 1; b < 4; b++) begin
        if (flags[a] && flags[b]) begin
          pair_t e;
          e.a  = a;
          e.b  = b;
          e.x0 = rx[b];
          e.x1 = rx[a];
          e.y0 = ry[b];
          e.y1 = ry[a];
          rx[a] = e.x0;
          rx[b] = e.x1;
          ry[a] = e.y0;
          ry[b] = e.y1;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  function automatic logic [51:0] upd_word();
    return {upd_if.upd_ID[0], upd_if.upd_ID[1],
            upd_if.upd_Xspeed[0], upd_if.upd_Xspeed[1],
            upd_if.upd_Yspeed[0], upd_if.upd_Yspeed[1]};
  endfunction

  task automatic writeback();
    bx[upd_if.upd_ID[0][1:0]] = upd_if.upd_Xspeed[0];
    bx[upd_if.upd_ID[1][1:0]] = upd_if.upd_Xspeed[1];
    by[upd_if.upd_ID[0][1:0]] = upd_if.upd_Yspeed[0];
    by[upd_if.upd_ID[1][1:0]] = upd_if.upd_Yspeed[1];
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_calc_id"}, {calc_ID[1], calc_ID[0]}, 0);
    chk({tag, "_calc_collide"}, calc_collide, 0);
    chk({tag, "_upd_valid"}, upd_if.upd_valid, 0);
    chk({tag, "_upd_data"}, upd_word(), 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_overrun"}, frame_overrun, 0);
    chk({tag, "_pair_count"}, pair_count, 0);
`ifdef SCHED_TIMEOUT_EN
    chk({tag, "_upd_timeout"}, upd_timeout, 0);
`endif
  endtask

  // One frame: SOF with flags, then per cycle check calculator drive,
  // overrun pulse, busy, handshake stability and delivered pairs.
  task automatic run_frame(input logic [3:0] flags, input int stall, input bit ovr,
                           input int ready_pct, input int exp_done, input int exp_count);
    int          cyc;
    int          stall_left;
    int          done_cyc;
    int          n_exp;
    bit          rdy;
    bit          held;
    bit          ovr_next;
    bit          done;
    logic [51:0] held_word;
    pair_t       e;
    model_frame(flags);
    n_exp = (exp_q.size() > 6) ? 6 : exp_q.size();
    @(negedge clk);
    balls_collide = flags;
    startOfFrame  = 1'b1;
    @(negedge clk);
    startOfFrame  = 1'b0;
    balls_collide = 4'($urandom);
    stall_left = stall;
    held       = 1'b0;
    ovr_next   = 1'b0;
    done       = 1'b0;
    done_cyc   = -1;
    held_word  = '0;
    cyc        = 1;
    while (cyc <= 400 && !done) begin
      if (calc_collide != 4'd0) begin
        chk("calc_id_order", calc_ID[0] < calc_ID[1], 1);
        chk("calc_collide_bits", calc_collide, (4'b0001 << calc_ID[0]) | (4'b0001 << calc_ID[1]));
      end else begin
        chk("calc_id_idle", {calc_ID[1], calc_ID[0]}, 0);
      end
      chk("frame_overrun", frame_overrun, ovr_next);
      ovr_next     = 1'b0;
      startOfFrame = 1'b0;
      if (held) begin
        chk("hold_valid", upd_if.upd_valid, 1);
        chk("hold_data", upd_word(), held_word);
      end
      if (frame_done) begin
        done     = 1'b1;
        done_cyc = cyc;
        chk("busy_at_done", busy, 0);
      end else begin
        chk("busy", busy, 1);
        rdy = ($urandom_range(99) < ready_pct);
        if (upd_if.upd_valid && stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
          if (ovr && stall_left == 10) begin
            startOfFrame  = 1'b1;
            balls_collide = ~flags;
            ovr_next      = 1'b1;
          end
        end
        upd_if.upd_ready = rdy;
        held      = upd_if.upd_valid && !rdy;
        held_word = upd_word();
        if (upd_if.upd_valid && rdy) begin
          if (exp_q.size() == 0) begin
            chk("extra_pair", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("upd_id0", upd_if.upd_ID[0], e.a);
            chk("upd_id1", upd_if.upd_ID[1], e.b);
            chk("upd_x0", upd_if.upd_Xspeed[0], e.x0);
            chk("upd_x1", upd_if.upd_Xspeed[1], e.x1);
            chk("upd_y0", upd_if.upd_Yspeed[0], e.y0);
            chk("upd_y1", upd_if.upd_Yspeed[1], e.y1);
          end
          writeback();
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) chk("frame_done_timeout", 0, 1);
    if (exp_done >= 0) chk("frame_done_cycle", done_cyc, exp_done);
    chk("pair_count", pair_count, (exp_count >= 0) ? exp_count : n_exp);
    chk("pairs_missing", exp_q.size(), 0);
    upd_if.upd_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    int tmo_cyc;
    int dn_cyc;
    checks           = 0;
    errors           = 0;
    reset            = 1'b1;
    startOfFrame     = 1'b0;
    balls_collide    = '0;
    upd_if.upd_ready = 1'b0;
    found            = 1'b0;
    tmo_cyc          = -1;
    dn_cyc           = -1;
    for (int k = 0; k < 4; k++) begin
      bx[k] = 11'(100 * k + 37);
      by[k] = 11'(-(50 * k + 5));
      rx[k] = bx[k];
      ry[k] = by[k];
    end

    vecs[0] = '{4'b0011, 0, 1'b0, 11, 1};
    vecs[1] = '{4'b1111, 0, 1'b0, 31, 6};
    vecs[2] = '{4'b0100, 0, 1'b0, 7, 0};
    vecs[3] = '{4'b0000, 0, 1'b0, 7, 0};
    vecs[4] = '{4'b1001, 0, 1'b0, 11, 1};
    vecs[5] = '{4'b1100, 0, 1'b0, 11, 1};
    vecs[6] = '{4'b0111, 0, 1'b0, 19, 3};
    vecs[7] = '{4'b0101, 20, 1'b1, 31, 1};
    vecs[8] = '{4'b1110, 0, 1'b0, 19, 3};

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    for (int v = 0; v < 9; v++) begin
      run_frame(vecs[v].flags, vecs[v].stall, vecs[v].ovr, 100,
                vecs[v].exp_done, vecs[v].exp_count);
    end

    // Reset while pair (0,2) is being driven; the next frame restarts at (0,1).
    upd_if.upd_ready = 1'b1;
    @(negedge clk);
    balls_collide = 4'b0111;
    startOfFrame  = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (calc_ID[0] == 4'd0 && calc_ID[1] == 4'd2) begin
        found = 1'b1;
      end else begin
        if (upd_if.upd_valid) writeback();
        @(negedge clk);
      end
    end
    chk("reach_drive_0_2", found, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midreset");
    reset = 1'b0;
    upd_if.upd_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rx[k] = bx[k];
      ry[k] = by[k];
    end
    run_frame(4'b0111, 0, 1'b0, 100, 19, 3);

    for (int r = 0; r < 25; r++) begin
      run_frame(4'($urandom), 0, 1'b0, $urandom_range(100, 30), -1, -1);
    end

`ifdef SCHED_TIMEOUT_EN
    upd_if.upd_ready = 1'b0;
    @(negedge clk);
    balls_collide = 4'b0011;
    startOfFrame  = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    for (int c = 1; c <= 400 && dn_cyc < 0; c++) begin
      if (upd_timeout) tmo_cyc = c;
      if (frame_done) dn_cyc = c;
      if (dn_cyc < 0) @(negedge clk);
    end
    chk("timeout_cycle", tmo_cyc, 261);
    chk("timeout_done_cycle", dn_cyc, 266);
    chk("timeout_pair_count", pair_count, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/collision_pair_scheduler.md
# collision_pair_scheduler

Sequences the combinational ball-pair speed calculator across every colliding ball pair in a frame. On `startOfFrame` it snapshots the per-ball collision flags and enumerates all flagged pairs in a fixed order. For each pair it drives the calculator's ID and collide inputs, waits a settle interval, and registers the two resulting speed vectors. It then hands them to the movement logic over a valid/ready handshake. It sits between the collision detector and the ball movement blocks, and makes the calculator shareable when more than two balls collide in one frame.

## Interface
Parameters
- `NUM_BALLS`, 4: number of balls; IDs 0..NUM_BALLS-1; ID width fixed at 4 bits.
- `CALC_WAIT`, 2: cycles `calc_ID`/`calc_collide` are held stable before capture; legal range 1..15.

Ports
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `startOfFrame`, in, 1: one-cycle frame pulse.
- `balls_collide`, in, NUM_BALLS: per-ball collision flags from the collision detector.
- `calc_Xspeed_in`, in, NUM_BALLS×11 signed: `Xspeed_VEC_out` of the calculator.
- `calc_Yspeed_in`, in, NUM_BALLS×11 signed: `Yspeed_VEC_out` of the calculator.
- `calc_ID`, out, 2×4: pair IDs to the calculator; [0] is the lower ID, [1] the higher.
- `calc_collide`, out, NUM_BALLS: collide vector to the calculator; exactly the two selected bits, or zero.
- `upd_valid`, out, 1: a pair result is presented.
- `upd_ready`, in, 1: consumer accepts the result.
- `upd_ID`, out, 2×4: IDs of the presented pair.
- `upd_Xspeed`, out, 2×11 signed: new X speeds, index matches `upd_ID`.
- `upd_Yspeed`, out, 2×11 signed: new Y speeds, index matches `upd_ID`.
- `busy`, out, 1: high in any state except IDLE.
- `frame_done`, out, 1: one-cycle pulse when the frame's pair list is exhausted.
- `frame_overrun`, out, 1: one-cycle pulse when `startOfFrame` arrives while busy.
- `pair_count`, out, 3: pairs delivered in the current or last frame.

## Operation
- States:
  - IDLE
  - SCAN
  - DRIVE
  - CAPTURE
  - PRESENT
- IDLE → SCAN on `startOfFrame`.
  - Latch `balls_collide` into `snap`.
  - Set pair pointer (i,j)=(0,1).
  - Clear `pair_count`.
- SCAN evaluates one candidate per cycle in lexicographic order: (0,1),(0,2),(0,3),(1,2),(1,3),(2,3).
  - If `snap[i]&&snap[j]`: go to DRIVE and load the wait counter with CALC_WAIT.
  - Otherwise advance the pointer.
  - After (NUM_BALLS-2,NUM_BALLS-1) with no hit: pulse `frame_done` and go to IDLE.
- DRIVE:
  - `calc_ID={j,i}`; `calc_collide` has only bits i and j set.
  - Counter decrements each cycle; go to CAPTURE when it reaches 1.
- CAPTURE: for one cycle, register `calc_Xspeed_in[i]`, `calc_Yspeed_in[i]`, `calc_Xspeed_in[j]`, `calc_Yspeed_in[j]` into the upd registers. Then go to PRESENT.
- PRESENT:
  - `upd_valid=1`; all upd outputs are held stable.
  - On `upd_valid&&upd_ready`: increment `pair_count`, advance the pointer, and return to SCAN.
  - If the accepted pair was the last candidate: pulse `frame_done` and go to IDLE.
- `calc_ID={0,0}` and `calc_collide=0` in every state except DRIVE and CAPTURE. Equal IDs force the calculator outputs to zero.
- A ball in several pairs is processed once per pair. Later pairs see the speeds the consumer has written back, provided writeback completes before the next DRIVE.
- Zero or one flagged ball: no pairs; `frame_done` pulses after the full scan.
- `startOfFrame` while busy:
  - Pulse `frame_overrun`.
  - Do not re-latch `snap`; the current sequence continues.
- `balls_collide` changes after latch: ignored until the next frame start from IDLE.

## Timing
- Reset values:
  - State IDLE; `busy` 0.
  - `calc_ID` {0,0}; `calc_collide` 0.
  - `upd_valid` 0; `upd_ID` 0; upd speeds 0.
  - `frame_done` 0; `frame_overrun` 0; `pair_count` 0.
- Reset asserted mid-operation:
  - The next edge returns to IDLE with reset values.
  - A pending result is dropped; `upd_valid` deasserts immediately.
- Per pair, with `upd_ready` held high: 1 (SCAN hit) + CALC_WAIT (DRIVE) + 1 (CAPTURE) + 1 (PRESENT) cycles.
- Each non-matching SCAN candidate costs 1 cycle.
- Worst case, NUM_BALLS=4 with all flagged and CALC_WAIT=2: 6×5 = 30 cycles, plus 1 cycle for the final `frame_done`.
- Handshake:
  - `upd_valid` never drops without acceptance except on reset.
  - Data is stable while valid.
  - The consumer may hold `upd_ready` low indefinitely.
- Outputs are registered; no combinational path from inputs to outputs.
- Arithmetic: speeds are passed through unchanged at 11 bits signed. The wait counter is 4 bits; `pair_count` saturates at 6.

## Configuration
- `SCHED_TIMEOUT_EN` defined:
  - PRESENT counts cycles with `upd_ready` low.
  - After 256 such cycles the pair is dropped: `upd_valid` deasserts, `pair_count` is not incremented, and the scheduler resumes SCAN.
  - The extra output `upd_timeout` (1 bit, reset 0) pulses for one cycle.
- Not defined: no counter, no `upd_timeout` port; PRESENT waits forever.

## Test plan
- Flags 4'b0011 at SOF, `upd_ready`=1, calculator model → one PRESENT with `upd_ID`={1,0}, `frame_done` 5+6 cycles after SOF, `pair_count`=1.
- Flags 4'b1111 → six pairs in order (0,1),(0,2),(0,3),(1,2),(1,3),(2,3); `calc_collide` shows exactly two bits per DRIVE; `pair_count`=6.
- Flags 4'b0100 → no DRIVE, `calc_ID` stays {0,0}, `frame_done` after 6 scan cycles, `pair_count`=0.
- Flags 4'b0101, `upd_ready` low for 20 cycles → `upd_valid` and data constant for 20 cycles, accepted on cycle 21; SOF pulsed during the wait → `frame_overrun` pulse, `snap` unchanged.
- Reset during DRIVE of pair (0,2) with flags 4'b0111 → next cycle IDLE, all outputs at reset values; next SOF restarts from (0,1).
- `SCHED_TIMEOUT_EN`, flags 4'b0011, `upd_ready`=0 → `upd_timeout` pulse after 256 cycles, `pair_count`=0, `frame_done` follows.
